// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer driving a single 1-bit full adder/subtractor slice.
// Operands are consumed LSB first, one bit per clock; done pulses when result and flags are valid.

module somador_subtrator (
    input  logic A,
    input  logic B,
    input  logic Te,
    input  logic M,
    output logic S,
    output logic Ts
);
    logic b_eff;
    logic c_eff;

    // M inverts B and the incoming carry, so Te must carry c^M to present the true carry c
    assign b_eff = B ^ M;
    assign c_eff = Te ^ M;
    assign S     = A ^ b_eff ^ c_eff;
    assign Ts    = (A & b_eff) | (c_eff & (A ^ b_eff));
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             m_reg;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             t_bit;
    logic             last_bit;
    logic             accept;

    somador_subtrator u_slice (
        .A  (a_sh[0]),
        .B  (b_sh[0]),
        .Te (c ^ m_reg),
        .M  (m_reg),
        .S  (s_bit),
        .Ts (t_bit)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            m_reg     <= 1'b0;
            c         <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            m_reg <= op_m;
            c     <= op_m;
            cnt   <= '0;
        end else if (state == BUSY) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            c      <= t_bit;
            result <= {s_bit, result[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                carry_out <= t_bit;
                // c still holds the carry into the MSB at this edge
                overflow  <= t_bit ^ c;
            end
        end
    end
endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
Bit-serial WIDTH-bit add/subtract sequencer built around the team's 1-bit full adder/subtractor (somador_subtrator, ports A, B, Te, M, S, Ts). It latches two operands and an operation mode on a start pulse. It then feeds the slice one bit per clock, LSB first, registering the carry between bits and shifting result bits into a result register. It sits directly upstream of the slice and consumes its S/Ts outputs, giving the datapath a multi-bit ALU at one-slice cost.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only when busy=0
op_m  input  1  mode sampled with start: 0 = A+B, 1 = A-B
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: result/flags valid
result  output  WIDTH  sum or difference, mod 2^WIDTH
carry_out  output  1  true carry out of MSB (sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, bit counter=0, carry reg=0. Reset takes priority over everything, including mid-operation; the current operation is discarded.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start=1 -> latch a, b, op_m into shift registers; carry reg c <= op_m; counter <= 0; go to BUSY.
  - BUSY: one bit per cycle. Slice inputs are A=a_sh[0], B=b_sh[0], M=m_reg, Te=c^m_reg. Because the slice internally applies Te^M, c holds the true carry and the first effective carry-in equals m_reg (two's complement +1 for subtract).
  - BUSY, each edge: c <= Ts; result shifts right with S inserted at MSB; a_sh and b_sh shift right; counter++.
  - BUSY, on the edge that processes bit WIDTH-1: carry_out <= Ts; overflow <= Ts ^ c (carry into MSB xor carry out of MSB); go to DONE.
  - DONE: done=1 for exactly this cycle. If start=1, accept a new operation exactly as in IDLE and go to BUSY; otherwise go to IDLE.
- busy=1 only in BUSY. start while BUSY is ignored, with no effect on operands or flags.
- Latency: start sampled at edge k -> BUSY during cycles k+1..k+WIDTH -> done high in the cycle after edge k+WIDTH. Interval from start to done is WIDTH+1 clocks.
- Back-to-back operations via start-in-DONE give a throughput of one operation per WIDTH+1 clocks.
- result, carry_out and overflow are partially updated during BUSY and must only be consumed when done=1. Their values are held stable from DONE until the next accepted start.
- Operand inputs are don't-care except in the cycle start is accepted.
- Widths: counter is clog2(WIDTH) bits and must not wrap before the terminal bit is detected.

Test Plan (WIDTH=8):
- Add: start with op_m=0, a=0x3C, b=0x25 -> done 9 clocks after start, result=0x61, carry_out=0, overflow=0. busy high for exactly 8 cycles.
- Add with unsigned and signed edges: 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0. 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
- Subtract: 0x50-0x30 -> result=0x20, carry_out=1, overflow=0. 0x10-0x20 -> result=0xF0, carry_out=0, overflow=0.
- Subtract signed overflow: 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1. 0x00-0x00 -> result=0x00, carry_out=1, overflow=0.
- Handshake: start pulsed again (a=0xAA) at the 3rd BUSY cycle -> ignored, first result unchanged. start asserted in the DONE cycle with 0x01+0x02 -> accepted, second done exactly 9 clocks later with result=0x03.
- Reset: rst=1 at the 4th BUSY cycle -> next cycle busy=0, done=0, result=0, carry_out=0, overflow=0, state IDLE. A new start after reset completes normally.
